if_id_ctrl: RTL and testbench
=============================

# if_id_ctrl

Instruction-fetch / decode boundary block sitting directly downstream of the program-counter stage. It takes the current word-addressed PC and the instruction read from instruction memory, and registers them into the IF/ID pipeline register. It detects control-transfer opcodes and drives the PC stage's hold (`jon10`), redirect (`jon2`) and opcode (`op_w`) inputs so that branches and jumps resolve after a fixed shadow with bubbles inserted. It also honours a downstream data-hazard stall.

## Interface

- `RESOLVE_CYCLES`, default 2: cycles from control-op capture to redirect. Legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pc_in` input 32: word address currently presented by the PC stage.
- `imem_rdata` input 32: instruction at `pc_in` (combinational memory read, valid in the same cycle).
- `ex_stall` input 1: downstream data-hazard stall request.
- `ir_out` output 32: IF/ID instruction register.
- `pc_id` output 32: PC of the instruction in `ir_out`.
- `valid_out` output 1: `ir_out` holds a real instruction (0 = bubble).
- `jon10` output 2: PC hold request. bit0 = data stall, bit1 = control shadow. Any set bit freezes the PC.
- `jon2` output 1: redirect strobe; the PC loads its next-PC function when `jon10==0`.
- `op_w` output 6: latched opcode of the pending control op, used by the PC stage's next-PC select.
- `instr_count` output 32: number of valid instructions captured into IF/ID.

## Operation

- Opcode field is `imem_rdata[31:26]`.
- Control ops: 32, 33, 34, 35 (branches) and 40, 41, 42 (jumps). All other opcodes are sequential.
- FSM states are RUN, WAIT and RESOLVE. A 4-bit shadow counter `cnt` is used in WAIT.
- **RUN, `ex_stall=1`:**
  - `jon10=2'b01`, `jon2=0`.
  - IF/ID and `instr_count` hold.
  - State stays RUN.
- **RUN, no stall, fetched op is a control op:**
  - `jon10=2'b10` (combinational from `imem_rdata`), `jon2=0`.
  - At the edge: IF/ID captures `imem_rdata`/`pc_in`, `valid_out<=1`, `instr_count++`, `op_w<=op`.
  - Next state is RESOLVE if `RESOLVE_CYCLES==1`. Otherwise next state is WAIT with `cnt<=RESOLVE_CYCLES-1`.
- **RUN, no stall, fetched op is sequential:**
  - `jon10=0`, `jon2=0`.
  - At the edge: capture into IF/ID, `valid_out<=1`, `instr_count++`.
  - The PC advances by 1.
- **WAIT:**
  - `jon10={1'b1, ex_stall}`, `jon2=0`.
  - At each edge: IF/ID loads a bubble (`ir_out<=0`, `valid_out<=0`, `pc_id` holds).
  - If `cnt==1`, go to RESOLVE; otherwise `cnt--`.
  - `ex_stall` does not freeze the count.
- **RESOLVE:**
  - If `ex_stall=1`: `jon10=2'b01`, `jon2=0`, stay in RESOLVE, IF/ID holds the bubble.
  - Otherwise: `jon10=0`, `jon2=1`, `op_w` stays valid; bubble loaded; next state RUN.
  - The PC loads the target (or fall-through for a not-taken branch) at this edge.
- `op_w` changes only on control-op capture. It holds its value through RUN otherwise.
- `instr_count` wraps 0xFFFFFFFF -> 0.
- Only one control op is in flight at a time; fetch is frozen during the shadow, so no nesting is possible.

## Timing

- **Reset (`rst=1`):**
  - State RUN; `cnt=0`.
  - `ir_out=0`, `pc_id=0`, `valid_out=0`, `op_w=0`, `instr_count=0`.
  - `jon10` and `jon2` are forced to 0 while `rst` is high, regardless of `imem_rdata`.
- **Reset mid-shadow:** an in-flight control op is abandoned immediately. No `jon2` pulse is issued.
- **Sequential fetch:** 1-cycle latency from `imem_rdata` to `ir_out`. Throughput is 1 instruction per cycle.
- **Control-op cost:** the PC is held for `RESOLVE_CYCLES` cycles with no stall. `jon2` is high for exactly 1 cycle. `RESOLVE_CYCLES` bubbles follow the control op in IF/ID.
- **Example, `RESOLVE_CYCLES=2`:**
  - c0 RUN: beq fetched, `jon10=10`.
  - c1 WAIT: `jon10=10`, `valid_out=1` (beq in IF/ID).
  - c2 RESOLVE: `jon2=1`, `op_w=32`, bubble.
  - c3 RUN: target instruction fetched.
- `jon10` and `jon2` are never both non-zero in the same cycle.

## Test plan

- **Sequential:** reset, then opcodes 0 at `pc_in` = 0,1,2,3 -> `ir_out`/`pc_id` follow one cycle later; `jon10=0`, `jon2=0`; `instr_count=4` after four edges.
- **Branch, `RESOLVE_CYCLES=2`:** op 32 at `pc_in=5` -> `jon10=10` for 2 cycles, then `jon2=1` for 1 cycle with `op_w=32`; `valid_out` sequence 1,0,0; `instr_count` increments once.
- **Jump, `RESOLVE_CYCLES=1`:** op 40 -> `jon10=10` for 1 cycle, `jon2=1` the next cycle, never in WAIT; then RUN.
- **Stall in RUN:** `ex_stall=1` for 3 cycles -> `jon10=01`, `ir_out`/`pc_id` unchanged, `instr_count` frozen; normal capture resumes on release.
- **Stall in RESOLVE:** `ex_stall=1` for 2 cycles -> `jon2` suppressed and `jon10=01`; `jon2=1` on the first cycle after release; exactly one redirect.
- **Reset mid-shadow:** assert `rst` while in WAIT -> all outputs zero; after release, state RUN and no `jon2` pulse.

Source files
------------

// File: rtl/if_id_ctrl.sv
// ----------------------------------------------------------------------------
// if_id_ctrl
//
// IF/ID boundary controller placed directly after the program-counter stage.
// It registers the fetched instruction and its PC into the IF/ID pipeline
// register, recognises control-transfer opcodes and steers the PC stage so
// that a branch or jump resolves after a fixed shadow of RESOLVE_CYCLES
// cycles, during which bubbles are fed into IF/ID. A downstream data-hazard
// stall freezes fetch while the pipeline is running or waiting to redirect.
//
// Parameters
//   RESOLVE_CYCLES : cycles from control-op capture to redirect (1..15)
//
// Ports
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous active-high reset
//   pc_in       in  32  word address presented by the PC stage
//   imem_rdata  in  32  instruction at pc_in (combinational read)
//   ex_stall    in   1  downstream data-hazard stall request
//   ir_out      out 32  IF/ID instruction register (0 for a bubble)
//   pc_id       out 32  PC of the instruction in ir_out
//   valid_out   out  1  ir_out holds a real instruction
//   jon10       out  2  PC hold: bit0 data stall, bit1 control shadow
//   jon2        out  1  one-cycle redirect strobe to the PC stage
//   op_w        out  6  opcode of the pending/last control op
//   instr_count out 32  count of valid instructions captured (wraps)
// ----------------------------------------------------------------------------
module if_id_ctrl #(
  parameter int RESOLVE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] imem_rdata,
  input  logic        ex_stall,
  output logic [31:0] ir_out,
  output logic [31:0] pc_id,
  output logic        valid_out,
  output logic [1:0]  jon10,
  output logic        jon2,
  output logic [5:0]  op_w,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;

  // Shadow counter start value; the capture cycle itself counts as the
  // first shadow cycle, so WAIT covers the remaining RESOLVE_CYCLES-1.
  localparam logic [3:0] CNT_INIT = 4'(RESOLVE_CYCLES - 1);

  function automatic logic is_ctrl_op(input logic [5:0] op);
    case (op)
      6'd32, 6'd33, 6'd34, 6'd35,
      6'd40, 6'd41, 6'd42:         is_ctrl_op = 1'b1;
      default:                     is_ctrl_op = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_q, valid_d;
  logic [5:0]  op_w_q, op_w_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic [1:0]  jon10_c;
  logic        jon2_c;

  logic [5:0]  fetch_op;
  logic        fetch_ctrl;

  assign fetch_op   = imem_rdata[31:26];
  assign fetch_ctrl = is_ctrl_op(fetch_op);

  // Next-state and PC-stage control
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ir_d          = ir_q;
    pc_id_d       = pc_id_q;
    valid_d       = valid_q;
    op_w_d        = op_w_q;
    instr_count_d = instr_count_q;
    jon10_c       = 2'b00;
    jon2_c        = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ex_stall) begin
          // IF/ID and the counter simply hold while the PC is frozen.
          jon10_c = 2'b01;
        end else begin
          ir_d          = imem_rdata;
          pc_id_d       = pc_in;
          valid_d       = 1'b1;
          instr_count_d = instr_count_q + 32'd1;
          if (fetch_ctrl) begin
            // Hold the PC immediately so the word after the control op
            // is never fetched.
            jon10_c = 2'b10;
            op_w_d  = fetch_op;
            if (RESOLVE_CYCLES == 1) begin
              state_d = ST_RESOLVE;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end

      ST_WAIT: begin
        // The shadow runs on regardless of ex_stall; the stall is only
        // reflected on the hold bus.
        jon10_c = {1'b1, ex_stall};
        ir_d    = 32'd0;
        valid_d = 1'b0;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESOLVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESOLVE: begin
        ir_d    = 32'd0;
        valid_d = 1'b0;
        if (ex_stall) begin
          // Defer the redirect until the downstream stall clears.
          jon10_c = 2'b01;
        end else begin
          jon2_c  = 1'b1;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // PC-stage strobes are quiet for the whole time reset is asserted.
  assign jon10 = rst ? 2'b00 : jon10_c;
  assign jon2  = rst ? 1'b0  : jon2_c;

  // State and IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      cnt_q         <= 4'd0;
      ir_q          <= 32'd0;
      pc_id_q       <= 32'd0;
      valid_q       <= 1'b0;
      op_w_q        <= 6'd0;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ir_q          <= ir_d;
      pc_id_q       <= pc_id_d;
      valid_q       <= valid_d;
      op_w_q        <= op_w_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign ir_out      = ir_q;
  assign pc_id       = pc_id_q;
  assign valid_out   = valid_q;
  assign op_w        = op_w_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_if_id_ctrl.sv
// ----------------------------------------------------------------------------
// tb_if_id_ctrl
//
// Three instances of if_id_ctrl (RESOLVE_CYCLES = 2, 1, 4) share one set of
// inputs. A behavioural model per instance tracks the IF/ID contents, the
// remaining shadow length and whether a redirect is still owed, and every
// cycle the outputs of all instances are compared with it. Directed phases
// pin the model with literal expectations; a random phase follows.
// ----------------------------------------------------------------------------
module tb_if_id_ctrl;

  localparam int N = 3;
  localparam logic [31:0] SEQ = 32'h0000_1000;
  localparam logic [31:0] BR  = 32'h8000_0000;  // opcode 32
  localparam logic [31:0] JMP = 32'hA000_0000;  // opcode 40

  logic        clk;
  logic        rst;
  logic        ex_stall;
  logic [31:0] pc_in;
  logic [31:0] imem_rdata;

  logic [31:0] ir_w    [N];
  logic [31:0] pc_id_w [N];
  logic        valid_w [N];
  logic [1:0]  jon10_w [N];
  logic        jon2_w  [N];
  logic [5:0]  op_w_w  [N];
  logic [31:0] cnt_w   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    if_id_ctrl #(
      .RESOLVE_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 4))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .pc_in      (pc_in),
      .imem_rdata (imem_rdata),
      .ex_stall   (ex_stall),
      .ir_out     (ir_w[g]),
      .pc_id      (pc_id_w[g]),
      .valid_out  (valid_w[g]),
      .jon10      (jon10_w[g]),
      .jon2       (jon2_w[g]),
      .op_w       (op_w_w[g]),
      .instr_count(cnt_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] m_ir    [N];
  logic [31:0] m_pc    [N];
  logic        m_val   [N];
  logic [5:0]  m_op    [N];
  logic [31:0] m_cnt   [N];
  int          m_shadow[N];  // shadow cycles still to run before redirect
  bit          m_owed  [N];  // a redirect has not yet been issued

  function automatic int rc_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  function automatic bit ctrl_op(input logic [5:0] op);
    return op inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd40, 6'd41, 6'd42};
  endfunction

  function automatic logic [1:0] exp_jon10(input int i);
    if (rst)              return 2'b00;
    if (m_shadow[i] > 0)  return {1'b1, ex_stall};
    if (ex_stall)         return 2'b01;
    if (m_owed[i])        return 2'b00;
    return ctrl_op(imem_rdata[31:26]) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic exp_jon2(input int i);
    return !rst && m_shadow[i] == 0 && m_owed[i] && !ex_stall;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ir[i] = '0; m_pc[i] = '0; m_val[i] = 1'b0; m_op[i] = '0;
      m_cnt[i] = '0; m_shadow[i] = 0; m_owed[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_shadow[i] > 0 || m_owed[i]) begin
        m_ir[i]  = '0;
        m_val[i] = 1'b0;
        if (m_shadow[i] > 0)  m_shadow[i]--;
        else if (!ex_stall)   m_owed[i] = 1'b0;
      end else if (!ex_stall) begin
        m_ir[i]  = imem_rdata;
        m_pc[i]  = pc_in;
        m_val[i] = 1'b1;
        m_cnt[i] = m_cnt[i] + 32'd1;
        if (ctrl_op(imem_rdata[31:26])) begin
          m_op[i]     = imem_rdata[31:26];
          m_owed[i]   = 1'b1;
          m_shadow[i] = rc_of(i) - 1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk("jon10",       i, 32'(jon10_w[i]), 32'(exp_jon10(i)));
      chk("jon2",        i, 32'(jon2_w[i]),  32'(exp_jon2(i)));
      chk("ir_out",      i, ir_w[i],         m_ir[i]);
      chk("pc_id",       i, pc_id_w[i],      m_pc[i]);
      chk("valid_out",   i, 32'(valid_w[i]), 32'(m_val[i]));
      chk("op_w",        i, 32'(op_w_w[i]),  32'(m_op[i]));
      chk("instr_count", i, cnt_w[i],        m_cnt[i]);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic s,
                       input logic [31:0] pc, input logic [31:0] ins);
    @(negedge clk);
    rst = r; ex_stall = s; pc_in = pc; imem_rdata = ins;
    if (r) model_reset();
    #1;
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
  endtask

  task automatic flush(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b0, 32'(base + k), SEQ + 32'(base + k));
      advance();
    end
  endtask

  initial begin
    rst = 1'b0; ex_stall = 1'b0; pc_in = '0; imem_rdata = '0;
    model_reset();
    #1 rst = 1'b1;

    // Reset, with a control op on the bus: strobes must stay low.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 32'd9, BR);
      chk("rst_jon10", 0, 32'(jon10_w[0]), 32'd0);
      chk("rst_valid", 0, 32'(valid_w[0]), 32'd0);
      chk("rst_count", 0, cnt_w[0], 32'd0);
      advance();
    end

    // Sequential fetch.
    for (int p = 0; p < 4; p++) begin
      drive(1'b0, 1'b0, 32'(p), SEQ + 32'(p));
      chk("seq_jon10", 0, 32'(jon10_w[0]), 32'd0);
      if (p > 0) begin
        chk("seq_ir", 0, ir_w[0], SEQ + 32'(p - 1));
        chk("seq_pc", 0, pc_id_w[0], 32'(p - 1));
      end
      advance();
    end

    // Branch at pc 5 (RC=2 on dut0, RC=1 on dut1).
    drive(1'b0, 1'b0, 32'd5, BR);
    chk("seq_cnt4", 0, cnt_w[0], 32'd4);
    chk("seq_ir3",  0, ir_w[0], SEQ + 32'd3);
    chk("br_c0_jon10", 0, 32'(jon10_w[0]), 32'd2);
    chk("br_c0_jon10", 1, 32'(jon10_w[1]), 32'd2);
    advance();
    drive(1'b0, 1'b0, 32'd6, SEQ + 32'd6);
    chk("br_c1_jon10", 0, 32'(jon10_w[0]), 32'd2);
    chk("br_c1_valid", 0, 32'(valid_w[0]), 32'd1);
    chk("br_c1_pc",    0, pc_id_w[0], 32'd5);
    chk("br_c1_cnt",   0, cnt_w[0], 32'd5);
    chk("jr1_c1_jon2", 1, 32'(jon2_w[1]), 32'd1);
    advance();
    drive(1'b0, 1'b0, 32'd6, SEQ + 32'd6);
    chk("br_c2_jon2",  0, 32'(jon2_w[0]), 32'd1);
    chk("br_c2_jon10", 0, 32'(jon10_w[0]), 32'd0);
    chk("br_c2_op",    0, 32'(op_w_w[0]), 32'd32);
    chk("br_c2_valid", 0, 32'(valid_w[0]), 32'd0);
    advance();
    drive(1'b0, 1'b0, 32'd7, SEQ + 32'd7);
    chk("br_c3_jon2",  0, 32'(jon2_w[0]), 32'd0);
    chk("br_c3_valid", 0, 32'(valid_w[0]), 32'd0);
    chk("br_c3_cnt",   0, cnt_w[0], 32'd5);
    advance();
    flush(8, 6);

    // Jump with RESOLVE_CYCLES=1 (dut1).
    drive(1'b0, 1'b0, 32'd20, JMP);
    chk("jmp_c0_jon10", 1, 32'(jon10_w[1]), 32'd2);
    advance();
    drive(1'b0, 1'b0, 32'd21, SEQ + 32'd21);
    chk("jmp_c1_jon2",  1, 32'(jon2_w[1]), 32'd1);
    chk("jmp_c1_jon10", 1, 32'(jon10_w[1]), 32'd0);
    chk("jmp_c1_op",    1, 32'(op_w_w[1]), 32'd40);
    advance();
    drive(1'b0, 1'b0, 32'd21, SEQ + 32'd21);
    chk("jmp_c2_jon2",  1, 32'(jon2_w[1]), 32'd0);
    chk("jmp_c2_valid", 1, 32'(valid_w[1]), 32'd0);
    advance();
    flush(21, 6);

    // Stall while running.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 32'd30, SEQ + 32'd30);
      chk("stall_jon10", 0, 32'(jon10_w[0]), 32'd1);
      chk("stall_ir",    0, ir_w[0], SEQ + 32'd26);
      chk("stall_pc",    0, pc_id_w[0], 32'd26);
      advance();
    end
    drive(1'b0, 1'b0, 32'd31, SEQ + 32'd31);
    chk("unstall_jon10", 0, 32'(jon10_w[0]), 32'd0);
    advance();
    drive(1'b0, 1'b0, 32'd32, SEQ + 32'd32);
    chk("unstall_ir", 0, ir_w[0], SEQ + 32'd31);
    advance();
    flush(33, 6);

    // Stall while resolving (dut0).
    drive(1'b0, 1'b0, 32'd40, BR);
    advance();
    drive(1'b0, 1'b0, 32'd41, SEQ + 32'd41);
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 32'd41, SEQ + 32'd41);
      chk("rs_stall_jon2",  0, 32'(jon2_w[0]), 32'd0);
      chk("rs_stall_jon10", 0, 32'(jon10_w[0]), 32'd1);
      advance();
    end
    drive(1'b0, 1'b0, 32'd41, SEQ + 32'd41);
    chk("rs_rel_jon2", 0, 32'(jon2_w[0]), 32'd1);
    advance();
    drive(1'b0, 1'b0, 32'd41, SEQ + 32'd41);
    chk("rs_after_jon2",  0, 32'(jon2_w[0]), 32'd0);
    chk("rs_after_jon10", 0, 32'(jon10_w[0]), 32'd0);
    advance();
    flush(42, 6);

    // Reset in the middle of a shadow.
    drive(1'b0, 1'b0, 32'd50, BR);
    advance();
    drive(1'b1, 1'b0, 32'd51, BR);
    chk("mid_rst_ir",    0, ir_w[0], 32'd0);
    chk("mid_rst_valid", 0, 32'(valid_w[0]), 32'd0);
    chk("mid_rst_op",    0, 32'(op_w_w[0]), 32'd0);
    chk("mid_rst_cnt",   0, cnt_w[0], 32'd0);
    chk("mid_rst_jon10", 0, 32'(jon10_w[0]), 32'd0);
    advance();
    drive(1'b0, 1'b0, 32'd52, SEQ + 32'd52);
    chk("post_rst_jon2",  0, 32'(jon2_w[0]), 32'd0);
    chk("post_rst_jon10", 0, 32'(jon10_w[0]), 32'd0);
    advance();
    drive(1'b0, 1'b0, 32'd53, SEQ + 32'd53);
    chk("post_rst_jon2b", 0, 32'(jon2_w[0]), 32'd0);
    chk("post_rst_cnt",   0, cnt_w[0], 32'd1);
    chk("post_rst_ir",    0, ir_w[0], SEQ + 32'd52);
    advance();

    // Random phase.
    for (int k = 0; k < 3000; k++) begin
      logic [5:0]  op;
      logic        r;
      logic        s;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 6))
          0: op = 6'd32;  1: op = 6'd33;  2: op = 6'd34;  3: op = 6'd35;
          4: op = 6'd40;  5: op = 6'd41;  default: op = 6'd42;
        endcase
      end else begin
        op = 6'($urandom_range(0, 63));
      end
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      drive(r, s, $urandom, {op, 26'($urandom)});
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
